cpl_credit_tracker: RTL and testbench
=====================================

# cpl_credit_tracker

Tag-aware completion-credit tracker for the PCIe read-request path. It sits between the read-request generator and the TLP transmit arbiter. It reserves completion header (CplH) and data (CplD) credits per outstanding tag, and returns them as completions arrive. Unlike the single-counter scheme, it allocates tags itself and returns any unused reservation when a tag finishes. It also honours the PCIe "0 = infinite" credit advertisement.

## Interface
Parameters:
- TAG_COUNT, 8 — outstanding tag slots; power of 2, 2..32
- HDR_W, 8 — CplH credit width
- DAT_W, 12 — CplD credit width
- MAX_PKTS, 0 — cap on outstanding tags; 0 = TAG_COUNT only

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- i_rcb_sel  in  1  RCB select; 1 = 128 B (32 DW), 0 = 64 B (16 DW)
- i_fc_cplh  in  HDR_W  advertised CplH credits; 0 = infinite
- i_fc_cpld  in  DAT_W  advertised CplD credits; 0 = infinite
- i_req_valid  in  1  request wants to issue
- i_req_dwords  in  10  request length in DW; 0 encodes 1024
- o_req_ready  out  1  request may issue this cycle
- o_req_tag  out  log2(TAG_COUNT)  tag assigned on handshake
- i_cpl_valid  in  1  completion TLP received
- i_cpl_tag  in  log2(TAG_COUNT)  completion tag
- i_cpl_dwords  in  10  completion payload DW; 0 encodes 1024
- i_cpl_last  in  1  final completion of this tag
- o_outstanding  out  log2(TAG_COUNT)+1  number of busy tags
- o_err  out  1  sticky protocol error (see Configuration)

## Operation
- Request cost, with L = DW length after the 0→1024 mapping:
  - hdr_need = ceil(L/R), where R = 32 if i_rcb_sel else 16.
  - dat_need = ceil(L/4).
  - Example: L=1024 at RCB 16 → hdr_need=64, dat_need=256.
- Availability, computed modulo the width:
  - hdr_avail = i_fc_cplh − hdr_in_flt
  - dat_avail = i_fc_cpld − dat_in_flt
- A channel is OK when its advertised value is 0, or when avail ≥ need.
- o_req_ready is asserted when all of the following hold:
  - both channels are OK;
  - a free tag exists;
  - MAX_PKTS is 0, or o_outstanding < MAX_PKTS.
- o_req_tag is the lowest-index free tag. It is valid whenever o_req_ready=1.
- Handshake (i_req_valid & o_req_ready):
  - the tag is marked busy;
  - the per-tag reservation is stored as hdr_res = hdr_need and dat_res = dat_need;
  - both in-flight counters are incremented.
- Completion on a busy tag:
  - hdr_rel = min(1, hdr_res[tag]).
  - dat_rel = min(ceil(C/4), dat_res[tag]), where C is the completion DW count after the 0→1024 mapping.
  - The tag's reservation and the in-flight counters are decremented by these amounts.
- If i_cpl_last is also set:
  - the whole remaining reservation of the tag is released instead;
  - the tag is freed.
- Completion on a free tag: no counter change.
- Simultaneous request and completion: the net delta is applied in one update (in_flt + req − rel). The request cannot take the tag being freed in that same cycle.
- In-flight counters never underflow, because releases are bounded by the per-tag reservation.
- Reset values: o_req_ready=1 after the first edge (all tags free, counters 0), o_req_tag=0, o_outstanding=0, o_err=0. All per-tag state is cleared.
- Reset mid-operation drops every reservation. Completions arriving after reset hit free tags and are ignored.

## Timing
- o_req_ready and o_req_tag are combinational from registered state and the current i_rcb_sel / i_req_dwords / i_fc_*.
- Handshake and completion effects are visible in o_req_ready, o_outstanding and the counters one cycle after the edge that sampled them.
- Back-to-back handshakes every cycle are supported.
- i_cpl_* carry no backpressure. One completion is accepted per cycle.

## Configuration
- CPL_ERR_CHECK_EN defined: o_err sets, and stays set until rst, on any of:
  - a completion to a free tag;
  - ceil(C/4) > dat_res[tag];
  - a non-last completion that drives hdr_res to 0.
- CPL_ERR_CHECK_EN undefined: o_err is tied to 0 and no check logic is built.

## Test plan
- fc_cplh=8, fc_cpld=64, RCB 64, request 64 DW → tag 0, hdr_in_flt=4, dat_in_flt=16; second 64 DW request → ready=1. A third request needs 4 hdr with avail 0 → ready=0.
- Request 1024 DW (encoded 0), RCB 128, fc 0/0 (infinite) → ready=1, hdr_res=32, dat_res=256. Send 8 completions of 128 DW, last on the 8th → counters return to 0 and the tag is freed.
- Request 100 DW → dat_res=25. A single last completion of 40 DW releases the full 25 data and 4 hdr credits.
- Same-cycle handshake on tag 1 and last completion on tag 0 → o_outstanding unchanged, and the next o_req_tag is 0.
- MAX_PKTS=2, fc infinite, three requests → the third waits until a last completion arrives.
- With CPL_ERR_CHECK_EN, a completion to a free tag → o_err=1 on the next cycle; without the macro, o_err stays 0.

Source files
------------

// File: rtl/cpl_credit_tracker_if.sv
// Request/completion/flow-control bundle between the read-request generator and cpl_credit_tracker.
// master drives the tracker inputs; slave is the tracker side.
interface cpl_credit_tracker_if #(
    parameter int TAG_COUNT = 8,
    parameter int HDR_W     = 8,
    parameter int DAT_W     = 12
);
    localparam int TAG_W = $clog2(TAG_COUNT);

    logic               i_rcb_sel;
    logic [HDR_W-1:0]   i_fc_cplh;
    logic [DAT_W-1:0]   i_fc_cpld;

    logic               i_req_valid;
    logic [9:0]         i_req_dwords;
    logic               o_req_ready;
    logic [TAG_W-1:0]   o_req_tag;

    logic               i_cpl_valid;
    logic [TAG_W-1:0]   i_cpl_tag;
    logic [9:0]         i_cpl_dwords;
    logic               i_cpl_last;

    logic [TAG_W:0]     o_outstanding;
    logic               o_err;

    modport master (
        output i_rcb_sel, i_fc_cplh, i_fc_cpld,
        output i_req_valid, i_req_dwords,
        input  o_req_ready, o_req_tag,
        output i_cpl_valid, i_cpl_tag, i_cpl_dwords, i_cpl_last,
        input  o_outstanding, o_err
    );

    modport slave (
        input  i_rcb_sel, i_fc_cplh, i_fc_cpld,
        input  i_req_valid, i_req_dwords,
        output o_req_ready, o_req_tag,
        input  i_cpl_valid, i_cpl_tag, i_cpl_dwords, i_cpl_last,
        output o_outstanding, o_err
    );
endinterface

// File: rtl/cpl_credit_tracker.sv
// Tag-aware CplH/CplD credit tracker: allocates tags, reserves credits per tag, releases on completion.
// Optional protocol checking on o_err is built only when CPL_ERR_CHECK_EN is defined.
module cpl_credit_tracker #(
    parameter int TAG_COUNT = 8,
    parameter int HDR_W     = 8,
    parameter int DAT_W     = 12,
    parameter int MAX_PKTS  = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    cpl_credit_tracker_if.slave  bus
);
    localparam int          TAG_W = $clog2(TAG_COUNT);
    localparam int unsigned MAX_U = MAX_PKTS;

    typedef logic [TAG_W-1:0] tag_t;

    logic [TAG_COUNT-1:0] busy;
    logic [HDR_W-1:0]     hdr_res [TAG_COUNT];
    logic [DAT_W-1:0]     dat_res [TAG_COUNT];
    logic [HDR_W-1:0]     hdr_in_flt;
    logic [DAT_W-1:0]     dat_in_flt;
    logic [TAG_W:0]       outstanding;

    logic [10:0]      req_len;
    logic [10:0]      cpl_len;
    logic [10:0]      req_round16;
    logic [10:0]      req_round32;
    logic [10:0]      req_round4;
    logic [10:0]      cpl_round4;
    logic [HDR_W-1:0] hdr_need;
    logic [DAT_W-1:0] dat_need;
    logic [DAT_W-1:0] cpl_dat;
    logic [HDR_W-1:0] hdr_avail;
    logic [DAT_W-1:0] dat_avail;
    logic             hdr_ok;
    logic             dat_ok;
    logic             pkt_ok;
    logic             free_found;
    tag_t             free_tag;
    logic             req_ready;
    logic             req_fire;

    // A length field of 0 stands for 1024 DW on both request and completion.
    assign req_len = (bus.i_req_dwords == 10'd0) ? 11'd1024 : {1'b0, bus.i_req_dwords};
    assign cpl_len = (bus.i_cpl_dwords == 10'd0) ? 11'd1024 : {1'b0, bus.i_cpl_dwords};

    assign req_round16 = req_len + 11'd15;
    assign req_round32 = req_len + 11'd31;
    assign req_round4  = req_len + 11'd3;
    assign cpl_round4  = cpl_len + 11'd3;

    assign hdr_need = bus.i_rcb_sel ? HDR_W'(req_round32[10:5]) : HDR_W'(req_round16[10:4]);
    assign dat_need = DAT_W'(req_round4[10:2]);
    assign cpl_dat  = DAT_W'(cpl_round4[10:2]);

    // Availability wraps with the counter width; an advertisement of 0 means unlimited.
    assign hdr_avail = bus.i_fc_cplh - hdr_in_flt;
    assign dat_avail = bus.i_fc_cpld - dat_in_flt;
    assign hdr_ok    = (bus.i_fc_cplh == '0) || (hdr_avail >= hdr_need);
    assign dat_ok    = (bus.i_fc_cpld == '0) || (dat_avail >= dat_need);
    assign pkt_ok    = (MAX_U == 0) || (32'(outstanding) < MAX_U);

    // Scan downwards so the last hit is the lowest-index free tag.
    always_comb begin
        free_found = 1'b0;
        free_tag   = '0;
        for (int i = TAG_COUNT - 1; i >= 0; i--) begin
            if (!busy[i]) begin
                free_found = 1'b1;
                free_tag   = tag_t'(i);
            end
        end
    end

    assign req_ready = hdr_ok && dat_ok && free_found && pkt_ok;
    assign req_fire  = bus.i_req_valid && req_ready;

    assign bus.o_req_ready   = req_ready;
    assign bus.o_req_tag     = free_tag;
    assign bus.o_outstanding = outstanding;

    logic             cpl_busy;
    logic             cpl_hit;
    logic             cpl_done;
    logic [HDR_W-1:0] cur_hdr;
    logic [DAT_W-1:0] cur_dat;
    logic [HDR_W-1:0] hdr_rel;
    logic [DAT_W-1:0] dat_rel;
    logic [HDR_W-1:0] hdr_inc;
    logic [DAT_W-1:0] dat_inc;
    logic [HDR_W-1:0] hdr_dec;
    logic [DAT_W-1:0] dat_dec;
    logic [TAG_W:0]   cnt_inc;
    logic [TAG_W:0]   cnt_dec;

    assign cpl_busy = busy[bus.i_cpl_tag];
    assign cpl_hit  = bus.i_cpl_valid && cpl_busy;
    assign cpl_done = cpl_hit && bus.i_cpl_last;
    assign cur_hdr  = hdr_res[bus.i_cpl_tag];
    assign cur_dat  = dat_res[bus.i_cpl_tag];

    // Releases are capped by the tag's reservation, so in-flight counters cannot underflow.
    always_comb begin
        hdr_rel = '0;
        dat_rel = '0;
        if (bus.i_cpl_last) begin
            hdr_rel = cur_hdr;
            dat_rel = cur_dat;
        end else begin
            hdr_rel = (cur_hdr != '0) ? HDR_W'(1) : '0;
            dat_rel = (cpl_dat < cur_dat) ? cpl_dat : cur_dat;
        end
    end

    assign hdr_inc = req_fire ? hdr_need : '0;
    assign dat_inc = req_fire ? dat_need : '0;
    assign hdr_dec = cpl_hit ? hdr_rel : '0;
    assign dat_dec = cpl_hit ? dat_rel : '0;
    assign cnt_inc = {{TAG_W{1'b0}}, req_fire};
    assign cnt_dec = {{TAG_W{1'b0}}, cpl_done};

    // A request always lands on a free tag and a release only on a busy one, so they never collide.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy        <= '0;
            hdr_in_flt  <= '0;
            dat_in_flt  <= '0;
            outstanding <= '0;
            for (int i = 0; i < TAG_COUNT; i++) begin
                hdr_res[i] <= '0;
                dat_res[i] <= '0;
            end
        end else begin
            hdr_in_flt  <= hdr_in_flt + hdr_inc - hdr_dec;
            dat_in_flt  <= dat_in_flt + dat_inc - dat_dec;
            outstanding <= outstanding + cnt_inc - cnt_dec;
            for (int i = 0; i < TAG_COUNT; i++) begin
                if (req_fire && (free_tag == tag_t'(i))) begin
                    busy[i]    <= 1'b1;
                    hdr_res[i] <= hdr_need;
                    dat_res[i] <= dat_need;
                end else if (cpl_hit && (bus.i_cpl_tag == tag_t'(i))) begin
                    hdr_res[i] <= cur_hdr - hdr_rel;
                    dat_res[i] <= cur_dat - dat_rel;
                    if (bus.i_cpl_last) begin
                        busy[i] <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef CPL_ERR_CHECK_EN
    logic err_q;
    logic err_now;

    assign err_now = (bus.i_cpl_valid && !cpl_busy)
                  || (cpl_hit && (cpl_dat > cur_dat))
                  || (cpl_hit && !bus.i_cpl_last && (cur_hdr <= HDR_W'(1)));

    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (err_now) begin
            err_q <= 1'b1;
        end
    end

    assign bus.o_err = err_q;
`else
    assign bus.o_err = 1'b0;
`endif

endmodule

// File: tb/tb_cpl_credit_tracker.sv
// Randomized and directed bench for cpl_credit_tracker against a per-tag reservation model.
// Second instance uses MAX_PKTS=2 to exercise the outstanding-tag cap.
module tb_cpl_credit_tracker;
    localparam int TAG_COUNT = 8;
    localparam int HDR_W     = 8;
    localparam int DAT_W     = 12;
    localparam int TAG_W     = $clog2(TAG_COUNT);
    localparam int HDR_MASK  = (1 << HDR_W) - 1;
    localparam int DAT_MASK  = (1 << DAT_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cpl_credit_tracker_if #(.TAG_COUNT(TAG_COUNT), .HDR_W(HDR_W), .DAT_W(DAT_W)) bus ();
    cpl_credit_tracker_if #(.TAG_COUNT(TAG_COUNT), .HDR_W(HDR_W), .DAT_W(DAT_W)) bus2 ();

    cpl_credit_tracker #(.TAG_COUNT(TAG_COUNT), .HDR_W(HDR_W), .DAT_W(DAT_W), .MAX_PKTS(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    cpl_credit_tracker #(.TAG_COUNT(TAG_COUNT), .HDR_W(HDR_W), .DAT_W(DAT_W), .MAX_PKTS(2)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2.slave)
    );

    int check_count = 0;
    int fail_count  = 0;

    // Model state: one reservation pair per busy tag; in-flight totals are the sums.
    bit m_busy [TAG_COUNT];
    int m_hres [TAG_COUNT];
    int m_dres [TAG_COUNT];
    bit m_err;

    bit e_ready;
    int e_tag;
    int e_out;
    int e_hneed;
    int e_dneed;

    `ifdef CPL_ERR_CHECK_EN
    localparam bit ERR_EN = 1'b1;
    `else
    localparam bit ERR_EN = 1'b0;
    `endif

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int lenOf(input logic [9:0] d);
        return (d == 10'd0) ? 1024 : int'(d);
    endfunction

    task automatic computeExpected();
        int hsum, dsum, r, len, havail, davail;
        bit found, hok, dok;
        hsum = 0; dsum = 0; e_out = 0; e_tag = 0; found = 0;
        for (int i = 0; i < TAG_COUNT; i++) begin
            if (m_busy[i]) begin
                hsum += m_hres[i];
                dsum += m_dres[i];
                e_out++;
            end
        end
        for (int i = TAG_COUNT - 1; i >= 0; i--) begin
            if (!m_busy[i]) begin
                e_tag = i;
                found = 1;
            end
        end
        len     = lenOf(bus.i_req_dwords);
        r       = bus.i_rcb_sel ? 32 : 16;
        e_hneed = (len + r - 1) / r;
        e_dneed = (len + 3) / 4;
        havail  = (int'(bus.i_fc_cplh) - hsum) & HDR_MASK;
        davail  = (int'(bus.i_fc_cpld) - dsum) & DAT_MASK;
        hok     = (bus.i_fc_cplh == '0) || (havail >= e_hneed);
        dok     = (bus.i_fc_cpld == '0) || (davail >= e_dneed);
        e_ready = hok && dok && found;
    endtask

    task automatic checkModel();
        computeExpected();
        checkOutput("ready", 32'(bus.o_req_ready), 32'(e_ready));
        if (e_ready) checkOutput("tag", 32'(bus.o_req_tag), 32'(e_tag));
        checkOutput("outstanding", 32'(bus.o_outstanding), 32'(e_out));
        checkOutput("err", 32'(bus.o_err), 32'(m_err));
    endtask

    task automatic updateModel();
        int t, cd;
        bit hs, e;
        computeExpected();
        if (rst) begin
            for (int i = 0; i < TAG_COUNT; i++) begin
                m_busy[i] = 0; m_hres[i] = 0; m_dres[i] = 0;
            end
            m_err = 0;
            return;
        end
        hs = bus.i_req_valid && e_ready;
        e  = 0;
        if (bus.i_cpl_valid) begin
            t = int'(bus.i_cpl_tag);
            if (!m_busy[t]) begin
                e = 1;
            end else begin
                cd = (lenOf(bus.i_cpl_dwords) + 3) / 4;
                if (cd > m_dres[t]) e = 1;
                if (bus.i_cpl_last) begin
                    m_hres[t] = 0; m_dres[t] = 0; m_busy[t] = 0;
                end else begin
                    if (m_hres[t] <= 1) e = 1;
                    if (m_hres[t] > 0) m_hres[t] -= 1;
                    m_dres[t] -= (cd < m_dres[t]) ? cd : m_dres[t];
                end
            end
        end
        if (hs) begin
            m_busy[e_tag] = 1;
            m_hres[e_tag] = e_hneed;
            m_dres[e_tag] = e_dneed;
        end
        if (ERR_EN && e) m_err = 1;
    endtask

    task automatic stepClock();
        @(posedge clk);
        updateModel();
        #1;
    endtask

    task automatic driveInputs(input logic rv, input logic [9:0] rdw, input logic cv,
                               input int ctag, input logic [9:0] cdw, input logic cl);
        bus.i_req_valid  = rv;
        bus.i_req_dwords = rdw;
        bus.i_cpl_valid  = cv;
        bus.i_cpl_tag    = TAG_W'(ctag);
        bus.i_cpl_dwords = cdw;
        bus.i_cpl_last   = cl;
    endtask

    task automatic applyStimulus(input logic rv, input logic [9:0] rdw, input logic cv,
                                 input int ctag, input logic [9:0] cdw, input logic cl);
        driveInputs(rv, rdw, cv, ctag, cdw, cl);
        #2;
        checkModel();
        stepClock();
    endtask

    task automatic setFc(input logic rcb, input int fch, input int fcd);
        bus.i_rcb_sel = rcb;
        bus.i_fc_cplh = HDR_W'(fch);
        bus.i_fc_cpld = DAT_W'(fcd);
    endtask

    task automatic doReset();
        rst = 1'b1;
        driveInputs(0, 10'd0, 0, 0, 10'd0, 0);
        stepClock();
        rst = 1'b0;
    endtask

    initial begin
        int ctag;
        bus.i_rcb_sel = 0; bus.i_fc_cplh = '0; bus.i_fc_cpld = '0;
        driveInputs(0, 10'd0, 0, 0, 10'd0, 0);
        bus2.i_rcb_sel = 0; bus2.i_fc_cplh = '0; bus2.i_fc_cpld = '0;
        bus2.i_req_valid = 0; bus2.i_req_dwords = 10'd4;
        bus2.i_cpl_valid = 0; bus2.i_cpl_tag = '0; bus2.i_cpl_dwords = 10'd4; bus2.i_cpl_last = 0;

        stepClock();
        stepClock();
        rst = 1'b0;
        #2;
        checkOutput("rst_ready", 32'(bus.o_req_ready), 32'd1);
        checkOutput("rst_tag", 32'(bus.o_req_tag), 32'd0);
        checkOutput("rst_outstanding", 32'(bus.o_outstanding), 32'd0);
        checkOutput("rst_err", 32'(bus.o_err), 32'd0);

        // MAX_PKTS=2 instance: third request waits for a last completion
        bus2.i_req_valid = 1;
        checkOutput("max_ready0", 32'(bus2.o_req_ready), 32'd1);
        checkOutput("max_tag0", 32'(bus2.o_req_tag), 32'd0);
        stepClock(); #2;
        checkOutput("max_tag1", 32'(bus2.o_req_tag), 32'd1);
        stepClock(); #2;
        checkOutput("max_ready2", 32'(bus2.o_req_ready), 32'd0);
        checkOutput("max_out2", 32'(bus2.o_outstanding), 32'd2);
        stepClock(); #2;
        checkOutput("max_ready_hold", 32'(bus2.o_req_ready), 32'd0);
        bus2.i_cpl_valid = 1; bus2.i_cpl_last = 1;
        stepClock();
        bus2.i_cpl_valid = 0; bus2.i_cpl_last = 0;
        #2;
        checkOutput("max_ready_after", 32'(bus2.o_req_ready), 32'd1);
        checkOutput("max_tag_after", 32'(bus2.o_req_tag), 32'd0);
        bus2.i_req_valid = 0;
        stepClock();

        // 64 DW at RCB 64 with fc 8/64: two fit, the third finds no header credit
        doReset();
        setFc(0, 8, 64);
        driveInputs(1, 10'd64, 0, 0, 10'd0, 0); #2;
        checkOutput("tp1_tag", 32'(bus.o_req_tag), 32'd0);
        checkModel(); stepClock();
        driveInputs(1, 10'd64, 0, 0, 10'd0, 0); #2;
        checkOutput("tp1_ready2", 32'(bus.o_req_ready), 32'd1);
        checkModel(); stepClock();
        driveInputs(1, 10'd64, 0, 0, 10'd0, 0); #2;
        checkOutput("tp1_ready3", 32'(bus.o_req_ready), 32'd0);
        checkModel(); stepClock();

        // 1024 DW with infinite credit, eight 128 DW completions
        doReset();
        setFc(1, 0, 0);
        applyStimulus(1, 10'd0, 0, 0, 10'd0, 0);
        for (int k = 0; k < 8; k++) applyStimulus(0, 10'd0, 1, 0, 10'd128, logic'(k == 7));
        setFc(1, 32, 256);
        driveInputs(0, 10'd0, 0, 0, 10'd0, 0); #2;
        checkOutput("tp2_ready", 32'(bus.o_req_ready), 32'd1);
        checkOutput("tp2_out", 32'(bus.o_outstanding), 32'd0);
        checkModel(); stepClock();

        // 100 DW reservation fully returned by a short last completion
        doReset();
        setFc(1, 4, 25);
        applyStimulus(1, 10'd100, 0, 0, 10'd0, 0);
        driveInputs(1, 10'd4, 0, 0, 10'd0, 0); #2;
        checkOutput("tp3_full", 32'(bus.o_req_ready), 32'd0);
        checkModel(); stepClock();
        applyStimulus(0, 10'd0, 1, 0, 10'd40, 1);
        driveInputs(0, 10'd100, 0, 0, 10'd0, 0); #2;
        checkOutput("tp3_returned", 32'(bus.o_req_ready), 32'd1);
        checkModel(); stepClock();

        // Same-cycle issue on tag 1 and last completion on tag 0
        doReset();
        setFc(0, 0, 0);
        applyStimulus(1, 10'd4, 0, 0, 10'd0, 0);
        driveInputs(1, 10'd4, 1, 0, 10'd4, 1); #2;
        checkOutput("tp4_tag1", 32'(bus.o_req_tag), 32'd1);
        checkModel(); stepClock();
        driveInputs(0, 10'd4, 0, 0, 10'd0, 0); #2;
        checkOutput("tp4_out", 32'(bus.o_outstanding), 32'd1);
        checkOutput("tp4_tag0", 32'(bus.o_req_tag), 32'd0);
        checkModel(); stepClock();

        // Completion to a free tag
        applyStimulus(0, 10'd4, 1, 5, 10'd4, 0);
        driveInputs(0, 10'd4, 0, 0, 10'd0, 0); #2;
        checkOutput("tp6_err", 32'(bus.o_err), 32'(ERR_EN));
        checkModel(); stepClock();

        // Random traffic, with a reset dropped into the middle
        doReset();
        for (int n = 0; n < 800; n++) begin
            if (n % 50 == 0) begin
                setFc(logic'($urandom_range(1)),
                      ($urandom_range(2) == 0) ? 0 : int'($urandom_range(60, 4)),
                      ($urandom_range(2) == 0) ? 0 : int'($urandom_range(600, 16)));
            end
            if (n == 400) begin
                doReset();
            end
            ctag = int'($urandom_range(TAG_COUNT - 1));
            if ($urandom_range(3) != 0) begin
                for (int j = 0; j < TAG_COUNT; j++) begin
                    if (m_busy[(ctag + j) % TAG_COUNT]) begin
                        ctag = (ctag + j) % TAG_COUNT;
                        break;
                    end
                end
            end
            applyStimulus(logic'($urandom_range(3) != 0),
                          ($urandom_range(7) == 0) ? 10'd0 : 10'($urandom_range(300, 1)),
                          logic'($urandom_range(1)), ctag,
                          10'($urandom_range(128, 1)),
                          logic'($urandom_range(2) == 0));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", check_count, fail_count);
        $finish;
    end
endmodule
